mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-ported unified memory between instruction fetch (IF) and data access (DM).
//  Sits between the pipeline's fetch/MW stages and the memory model.
//  Sequences each access with a small FSM, forms byte enables from mem_acc_mode,
//  and aligns/sign-extends load data. Its wait signals feed hazard_unit to stall the pipeline.
// PARAMETERS
//  AW          32  address width (byte address)
//  DW          32  data width; only 32 is supported
//  STARVE_MAX  4   consecutive DM grants with IF waiting before IF is forced (only with ARB_STARVE_GUARD_EN)
// PORTS
//  clk           in   1   clock; all logic on posedge
//  rst_n         in   1   synchronous reset, active low
//  if_req        in   1   fetch request; held until if_ack
//  if_addr       in   AW  fetch address; word aligned
//  if_ack        out  1   fetch done (1-cycle pulse); if_rdata valid in this cycle
//  if_rdata      out  DW  instruction word
//  dm_req        in   1   data request; held until dm_ack
//  dm_we         in   1   1 = store, 0 = load
//  dm_addr       in   AW  byte address
//  dm_wdata      in   DW  store data; LSBs hold the value
//  dm_mode       in   3   funct3 access mode: 000 B, 001 H, 010 W, 100 BU, 101 HU
//  dm_ack        out  1   data done (1-cycle pulse); dm_rdata and dm_err valid in this cycle
//  dm_rdata      out  DW  aligned, extended load data; 0 for stores
//  dm_err        out  1   misaligned access or illegal mode; valid with dm_ack
//  if_wait       out  1   if_req & ~if_ack (to hazard unit)
//  dm_wait       out  1   dm_req & ~dm_ack (to hazard unit)
//  mem_req       out  1   memory request; held until mem_ack
//  mem_we        out  1   memory write
//  mem_addr      out  AW  word-aligned address ({addr[AW-1:2],2'b00})
//  mem_be        out  4   byte enables
//  mem_wdata     out  DW  store data shifted to its byte lane
//  mem_ack       in   1   memory done; mem_rdata valid in this cycle
//  mem_rdata     in   DW  raw word read
// BEHAVIOUR
//  Reset (rst_n==0 at posedge):
//   - state IDLE; all mem_* outputs 0; starve count 0.
//   - if_ack, dm_ack and dm_err are 0.
//   - An in-flight access is abandoned; the memory must tolerate mem_req dropping.
//  FSM states: IDLE, BUSY_I, BUSY_D, ERR_D.
//  IDLE arbitration:
//   - dm_req and misaligned (H with addr[0]; W with addr[1:0]!=0) or illegal mode -> ERR_D.
//   - else dm_req -> BUSY_D.
//   - else if_req -> BUSY_I.
//   - else stay in IDLE.
//   - On a grant, addr, we, be and shifted wdata are registered.
//  BUSY_x:
//   - mem_req=1 with the registered fields.
//   - On mem_ack: x_ack=1 combinationally in the same cycle, then next state is IDLE.
//  ERR_D: dm_ack=1, dm_err=1, no memory access; next state is IDLE.
//  Latency:
//   - Grant edge t; mem_req is high from t+1. The ack coincides with the first mem_ack.
//   - Minimum access is 2 cycles: 1 IDLE plus 1 BUSY. There is no back-to-back issue from BUSY.
//  Priority:
//   - DM beats IF on simultaneous requests, because DM belongs to the older instruction.
//   - A request arriving while the other requester is in BUSY waits until IDLE.
//  Byte enables (off = addr[1:0]):
//   - B: 4'b0001<<off
//   - H: 4'b0011<<off
//   - W: 4'b1111
//   - mem_wdata = dm_wdata << (8*off).
//  Load data:
//   - Raw word = mem_rdata >> (8*off); take the low 8 or 16 bits.
//   - B/H sign-extend; BU/HU zero-extend; W passes through.
//  Stores: dm_rdata=0.
//  IF: if_rdata = mem_rdata in BUSY_I, else 0.
//  Requesters dropping req before ack is illegal; the arbiter completes the access regardless.
// CONFIGURATION
//  ARB_STARVE_GUARD_EN defined:
//   - A counter increments on each DM grant while if_req is high, and clears on any IF grant.
//   - When count==STARVE_MAX and both requests are present in IDLE, IF is granted.
//  ARB_STARVE_GUARD_EN undefined: strict DM priority; no counter logic exists.
// STRUCTURE
//  Package mem_arb_pkg:
//   - typedef enum logic[2:0] acc_mode_e {MODE_B, MODE_H, MODE_W, MODE_BU, MODE_HU}
//   - typedef enum arb_state_e
//   - localparam WORD_BYTES = 4
//  Sub-module mem_lane_fmt (combinational):
//   - inputs mode, off, wdata, raw rdata
//   - outputs be, shifted wdata, extended rdata, misalign flag.
// TESTING
//  1. Reset: rst_n=0 for 2 cycles -> mem_req=0, if_ack=0, dm_ack=0.
//     Release, if_req@0x100, mem_ack 1 cycle after mem_req -> if_ack with if_rdata=mem word.
//  2. Simultaneous if_req and dm_req (LW 0x200) -> mem_addr=0x200 first.
//     IF is issued after the DM ack; if_wait stays high throughout.
//  3. SB 0xAB to 0x203 -> mem_be=4'b1000, mem_wdata=0xAB000000, mem_we=1.
//  4. LB 0x202, mem_rdata=0x0080_0000 -> dm_rdata=0xFFFFFF80.
//     LBU same address -> 0x00000080.
//  5. LH at 0x201 -> dm_ack and dm_err=1 two cycles after req; mem_req never asserted.
//  6. Reset asserted with mem_req high -> mem_req=0 next cycle, no ack.
//     With ARB_STARVE_GUARD_EN and STARVE_MAX=4: 4 DM grants while IF waits, then IF wins the fifth arbitration.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types for the IF/DM memory port arbiter.
// Access modes follow RISC-V load/store funct3 encoding.
package mem_arb_pkg;

    typedef enum logic [2:0] {
        MODE_B  = 3'b000,
        MODE_H  = 3'b001,
        MODE_W  = 3'b010,
        MODE_BU = 3'b100,
        MODE_HU = 3'b101
    } acc_mode_e;

    typedef enum logic [1:0] {
        IDLE,
        BUSY_I,
        BUSY_D,
        ERR_D
    } arb_state_e;

    localparam int WORD_BYTES = 4;

endpackage

// File: rtl/mem_lane_fmt.sv
// mem_lane_fmt: byte-lane enables, store shifting, load alignment and
// extension, plus misalignment / illegal-mode detection.
module mem_lane_fmt
    import mem_arb_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic [2:0]            mode,
    input  logic [1:0]            off,
    input  logic [DW-1:0]         wdata,
    input  logic [DW-1:0]         raw,
    output logic [WORD_BYTES-1:0] be,
    output logic [DW-1:0]         wdata_sh,
    output logic [DW-1:0]         rdata_ext,
    output logic                  misalign,
    output logic                  illegal
);

    logic [DW-1:0] sh;

    always_comb begin
        be        = '0;
        misalign  = 1'b0;
        illegal   = 1'b0;
        sh        = raw >> {off, 3'b000};
        rdata_ext = sh;
        wdata_sh  = wdata << {off, 3'b000};
        case (acc_mode_e'(mode))
            MODE_B: begin
                be        = 4'b0001 << off;
                rdata_ext = {{(DW-8){sh[7]}}, sh[7:0]};
            end
            MODE_BU: begin
                be        = 4'b0001 << off;
                rdata_ext = {{(DW-8){1'b0}}, sh[7:0]};
            end
            MODE_H: begin
                be        = 4'b0011 << off;
                misalign  = off[0];
                rdata_ext = {{(DW-16){sh[15]}}, sh[15:0]};
            end
            MODE_HU: begin
                be        = 4'b0011 << off;
                misalign  = off[0];
                rdata_ext = {{(DW-16){1'b0}}, sh[15:0]};
            end
            MODE_W: begin
                be       = 4'b1111;
                misalign = |off;
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between IF and DM.
// Define ARB_STARVE_GUARD_EN to bound how long DM traffic can block IF.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  if_req,
    input  logic [AW-1:0]         if_addr,
    output logic                  if_ack,
    output logic [DW-1:0]         if_rdata,
    input  logic                  dm_req,
    input  logic                  dm_we,
    input  logic [AW-1:0]         dm_addr,
    input  logic [DW-1:0]         dm_wdata,
    input  logic [2:0]            dm_mode,
    output logic                  dm_ack,
    output logic [DW-1:0]         dm_rdata,
    output logic                  dm_err,
    output logic                  if_wait,
    output logic                  dm_wait,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [AW-1:0]         mem_addr,
    output logic [WORD_BYTES-1:0] mem_be,
    output logic [DW-1:0]         mem_wdata,
    input  logic                  mem_ack,
    input  logic [DW-1:0]         mem_rdata
);

    arb_state_e state, state_nxt;

    logic [AW-1:0]         r_addr;
    logic                  r_we;
    logic [WORD_BYTES-1:0] r_be;
    logic [DW-1:0]         r_wdata;
    logic [2:0]            r_mode;
    logic [1:0]            r_off;

    logic [2:0]            f_mode;
    logic [1:0]            f_off;
    logic [WORD_BYTES-1:0] f_be;
    logic [DW-1:0]         f_wdata;
    logic [DW-1:0]         f_rdata;
    logic                  f_misalign;
    logic                  f_illegal;

    logic grant_i, grant_d, grant_e;
    logic if_first;
    logic idle;

    assign idle = (state == IDLE);

    // Live request fields while arbitrating, latched ones once busy.
    assign f_mode = idle ? dm_mode      : r_mode;
    assign f_off  = idle ? dm_addr[1:0] : r_off;

    mem_lane_fmt #(.DW(DW)) u_fmt (
        .mode      (f_mode),
        .off       (f_off),
        .wdata     (dm_wdata),
        .raw       (mem_rdata),
        .be        (f_be),
        .wdata_sh  (f_wdata),
        .rdata_ext (f_rdata),
        .misalign  (f_misalign),
        .illegal   (f_illegal)
    );

`ifdef ARB_STARVE_GUARD_EN
    localparam int CW = $clog2(STARVE_MAX + 1);
    logic [CW-1:0] starve_cnt;
    logic          unused_addr;

    assign unused_addr = ^if_addr[1:0];
    assign if_first = if_req & dm_req &
                      (starve_cnt == CW'(STARVE_MAX));

    always_ff @(posedge clk) begin
        if (!rst_n)
            starve_cnt <= '0;
        else if (grant_i)
            starve_cnt <= '0;
        else if ((grant_d | grant_e) & if_req &
                 (starve_cnt != CW'(STARVE_MAX)))
            starve_cnt <= starve_cnt + 1'b1;
    end
`else
    logic unused_cfg;

    assign unused_cfg = ^if_addr[1:0] ^ (STARVE_MAX != 0);
    assign if_first   = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        grant_i   = 1'b0;
        grant_d   = 1'b0;
        grant_e   = 1'b0;
        unique case (state)
            IDLE: begin
                if (if_first) begin
                    grant_i   = 1'b1;
                    state_nxt = BUSY_I;
                end else if (dm_req & (f_misalign | f_illegal)) begin
                    grant_e   = 1'b1;
                    state_nxt = ERR_D;
                end else if (dm_req) begin
                    grant_d   = 1'b1;
                    state_nxt = BUSY_D;
                end else if (if_req) begin
                    grant_i   = 1'b1;
                    state_nxt = BUSY_I;
                end
            end
            BUSY_I, BUSY_D: begin
                if (mem_ack)
                    state_nxt = IDLE;
            end
            ERR_D:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_addr  <= '0;
            r_we    <= 1'b0;
            r_be    <= '0;
            r_wdata <= '0;
            r_mode  <= '0;
            r_off   <= '0;
        end else if (grant_i) begin
            r_addr  <= {if_addr[AW-1:2], 2'b00};
            r_we    <= 1'b0;
            r_be    <= '1;
            r_wdata <= '0;
        end else if (grant_d) begin
            r_addr  <= {dm_addr[AW-1:2], 2'b00};
            r_we    <= dm_we;
            r_be    <= f_be;
            r_wdata <= f_wdata;
            r_mode  <= dm_mode;
            r_off   <= dm_addr[1:0];
        end
    end

    assign mem_req   = (state == BUSY_I) | (state == BUSY_D);
    assign mem_we    = r_we;
    assign mem_addr  = r_addr;
    assign mem_be    = r_be;
    assign mem_wdata = r_wdata;

    assign if_ack   = (state == BUSY_I) & mem_ack;
    assign if_rdata = (state == BUSY_I) ? mem_rdata : '0;

    assign dm_ack   = ((state == BUSY_D) & mem_ack) | (state == ERR_D);
    assign dm_err   = (state == ERR_D);
    assign dm_rdata = ((state == BUSY_D) & ~r_we) ? f_rdata : '0;

    assign if_wait = if_req & ~if_ack;
    assign dm_wait = dm_req & ~dm_ack;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed vector table plus hand-written sequences
// for arbitration order, reset abort and DM-vs-IF starvation.
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ack;
    logic [31:0] if_rdata;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [2:0]  dm_mode;
    logic        dm_ack;
    logic [31:0] dm_rdata;
    logic        dm_err;
    logic        if_wait;
    logic        dm_wait;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    mem_port_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_ack    (if_ack),
        .if_rdata  (if_rdata),
        .dm_req    (dm_req),
        .dm_we     (dm_we),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_mode   (dm_mode),
        .dm_ack    (dm_ack),
        .dm_rdata  (dm_rdata),
        .dm_err    (dm_err),
        .if_wait   (if_wait),
        .dm_wait   (dm_wait),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_be    (mem_be),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory model: acks one cycle after it first sees mem_req.
    logic [31:0] mem_word;
    logic        seen;
    initial begin
        mem_ack   = 1'b0;
        mem_rdata = '0;
        seen      = 1'b0;
        forever begin
            @(negedge clk);
            if (mem_req && !mem_ack) begin
                if (seen) begin
                    mem_ack   = 1'b1;
                    mem_rdata = mem_word;
                    seen      = 1'b0;
                end else begin
                    seen = 1'b1;
                end
            end else begin
                mem_ack   = 1'b0;
                mem_rdata = '0;
                seen      = 1'b0;
            end
        end
    end

    int tests;
    int failed;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [2:0]  mode;
        logic [31:0] wdata;
        logic [31:0] word;
        logic        err;
        logic [3:0]  be;
        logic [31:0] mw;
        logic [31:0] rd;
    } vec_t;

    vec_t vt[14];

    int          c_cyc;
    logic        c_err;
    logic [31:0] c_rd;
    logic [3:0]  c_be;
    logic [31:0] c_mw;
    logic [31:0] c_addr;
    logic        c_we;
    logic        c_seen;

    task automatic run_dm(input vec_t v);
        c_cyc  = 0;
        c_err  = 1'b0;
        c_rd   = '0;
        c_be   = '0;
        c_mw   = '0;
        c_addr = '0;
        c_we   = 1'b0;
        c_seen = 1'b0;
        mem_word = v.word;
        dm_we    = v.we;
        dm_addr  = v.addr;
        dm_mode  = v.mode;
        dm_wdata = v.wdata;
        dm_req   = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            step();
            if (mem_req && !c_seen) begin
                c_seen = 1'b1;
                c_be   = mem_be;
                c_mw   = mem_wdata;
                c_addr = mem_addr;
                c_we   = mem_we;
            end
            if (dm_ack) begin
                c_cyc  = i;
                c_err  = dm_err;
                c_rd   = dm_rdata;
                dm_req = 1'b0;
                break;
            end
        end
        dm_req = 1'b0;
        step();
    endtask

    int          cyc;
    int          acks;
    logic        got;
    logic        dm_done;
    logic        if_done;
    logic        wait_ok;
    logic        first_seen;
    logic [31:0] first_addr;
    logic [31:0] if_maddr;
    logic [31:0] cap;
    logic [31:0] cap2;

`ifdef ARB_STARVE_GUARD_EN
    localparam int EXP_DM = 4;
`else
    localparam int EXP_DM = 5;
`endif

    initial begin
        tests    = 0;
        failed   = 0;
        rst_n    = 1'b0;
        if_req   = 1'b0;
        if_addr  = '0;
        dm_req   = 1'b0;
        dm_we    = 1'b0;
        dm_addr  = '0;
        dm_wdata = '0;
        dm_mode  = 3'b010;
        mem_word = '0;

        //    we    addr         mode    wdata         word          err   be     mw            rd
        vt[0]  = '{1'b0, 32'h200, 3'b010, 32'h0,        32'h11223344, 1'b0, 4'hF, 32'h0,        32'h11223344};
        vt[1]  = '{1'b1, 32'h203, 3'b000, 32'hAB,       32'hFFFFFFFF, 1'b0, 4'h8, 32'hAB000000, 32'h0};
        vt[2]  = '{1'b0, 32'h202, 3'b000, 32'h0,        32'h00800000, 1'b0, 4'h4, 32'h0,        32'hFFFFFF80};
        vt[3]  = '{1'b0, 32'h202, 3'b100, 32'h0,        32'h00800000, 1'b0, 4'h4, 32'h0,        32'h00000080};
        vt[4]  = '{1'b0, 32'h202, 3'b001, 32'h0,        32'h80010000, 1'b0, 4'hC, 32'h0,        32'hFFFF8001};
        vt[5]  = '{1'b0, 32'h200, 3'b101, 32'h0,        32'h0000F00D, 1'b0, 4'h3, 32'h0,        32'h0000F00D};
        vt[6]  = '{1'b1, 32'h302, 3'b001, 32'h1234,     32'hFFFFFFFF, 1'b0, 4'hC, 32'h12340000, 32'h0};
        vt[7]  = '{1'b1, 32'h304, 3'b010, 32'hDEADBEEF, 32'hFFFFFFFF, 1'b0, 4'hF, 32'hDEADBEEF, 32'h0};
        vt[8]  = '{1'b0, 32'h201, 3'b000, 32'h0,        32'h00007F00, 1'b0, 4'h2, 32'h0,        32'h0000007F};
        vt[9]  = '{1'b0, 32'h201, 3'b001, 32'h0,        32'h0,        1'b1, 4'h0, 32'h0,        32'h0};
        vt[10] = '{1'b0, 32'h202, 3'b010, 32'h0,        32'h0,        1'b1, 4'h0, 32'h0,        32'h0};
        vt[11] = '{1'b0, 32'h200, 3'b011, 32'h0,        32'h0,        1'b1, 4'h0, 32'h0,        32'h0};
        vt[12] = '{1'b1, 32'h201, 3'b000, 32'hCD,       32'hFFFFFFFF, 1'b0, 4'h2, 32'h0000CD00, 32'h0};
        vt[13] = '{1'b0, 32'h202, 3'b101, 32'h0,        32'h80010000, 1'b0, 4'hC, 32'h0,        32'h00008001};

        // Reset state
        step();
        step();
        chk("rst mem_req", 32'(mem_req), 32'd0);
        chk("rst if_ack",  32'(if_ack),  32'd0);
        chk("rst dm_ack",  32'(dm_ack),  32'd0);
        chk("rst mem_be",  32'(mem_be),  32'd0);
        chk("rst mem_addr", mem_addr,    32'd0);
        rst_n = 1'b1;
        step();

        // Single fetch
        mem_word = 32'h00000013;
        if_addr  = 32'h100;
        if_req   = 1'b1;
        cyc = 0;
        cap = '0;
        cap2 = '0;
        first_seen = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            step();
            if (mem_req && !first_seen) begin
                first_seen = 1'b1;
                cap  = mem_addr;
                cap2 = {27'd0, mem_we, mem_be};
            end
            if (if_ack) begin
                cyc = i;
                if_req = 1'b0;
                chk("if rdata", if_rdata, 32'h00000013);
                break;
            end
        end
        if_req = 1'b0;
        chk("if ack cycle", 32'(cyc), 32'd2);
        chk("if mem_addr", cap, 32'h100);
        chk("if we/be", cap2, 32'h0000000F);
        step();

        // Vector table
        foreach (vt[k]) begin
            run_dm(vt[k]);
            chk($sformatf("v%0d err", k), 32'(c_err), 32'(vt[k].err));
            if (vt[k].err) begin
                chk($sformatf("v%0d cyc", k), 32'(c_cyc), 32'd1);
                chk($sformatf("v%0d memreq", k), 32'(c_seen), 32'd0);
            end else begin
                chk($sformatf("v%0d cyc", k), 32'(c_cyc), 32'd2);
                chk($sformatf("v%0d be", k), 32'(c_be), 32'(vt[k].be));
                chk($sformatf("v%0d wdata", k), c_mw, vt[k].mw);
                chk($sformatf("v%0d addr", k), c_addr,
                    {vt[k].addr[31:2], 2'b00});
                chk($sformatf("v%0d we", k), 32'(c_we), 32'(vt[k].we));
                chk($sformatf("v%0d rdata", k), c_rd, vt[k].rd);
            end
        end

        // Simultaneous IF and DM: DM first, IF waits throughout
        mem_word = 32'hCAFEF00D;
        if_addr  = 32'h400;
        if_req   = 1'b1;
        dm_we    = 1'b0;
        dm_addr  = 32'h200;
        dm_mode  = 3'b010;
        dm_req   = 1'b1;
        first_seen = 1'b0;
        first_addr = '0;
        if_maddr = '0;
        wait_ok = 1'b1;
        dm_done = 1'b0;
        if_done = 1'b0;
        cap = '0;
        cap2 = '0;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (i == 1)
                chk("both dm_wait", 32'(dm_wait), 32'd1);
            if (mem_req && !first_seen) begin
                first_seen = 1'b1;
                first_addr = mem_addr;
            end
            if (mem_req && dm_done)
                if_maddr = mem_addr;
            if (!if_ack && !if_wait)
                wait_ok = 1'b0;
            if (dm_ack && !dm_done) begin
                dm_done = 1'b1;
                cap = dm_rdata;
                dm_req = 1'b0;
                mem_word = 32'h00000513;
            end
            if (if_ack) begin
                if_done = dm_done;
                cap2 = if_rdata;
                if_req = 1'b0;
                break;
            end
        end
        if_req = 1'b0;
        dm_req = 1'b0;
        chk("both first addr", first_addr, 32'h200);
        chk("both if_wait", 32'(wait_ok), 32'd1);
        chk("both dm rdata", cap, 32'hCAFEF00D);
        chk("both if after dm", 32'(if_done), 32'd1);
        chk("both if addr", if_maddr, 32'h400);
        chk("both if rdata", cap2, 32'h00000513);
        step();

        // Reset while mem_req is high
        mem_word = 32'h12345678;
        dm_addr = 32'h200;
        dm_mode = 3'b010;
        dm_we   = 1'b0;
        dm_req  = 1'b1;
        step();
        chk("abort memreq up", 32'(mem_req), 32'd1);
        rst_n  = 1'b0;
        dm_req = 1'b0;
        step();
        chk("abort memreq", 32'(mem_req), 32'd0);
        chk("abort dm_ack", 32'(dm_ack), 32'd0);
        rst_n = 1'b1;
        acks = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (dm_ack || if_ack || mem_req)
                acks++;
        end
        chk("abort quiet", 32'(acks), 32'd0);

        // DM held continuously against a waiting IF
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
        mem_word = '0;
        if_addr  = 32'h500;
        if_req   = 1'b1;
        dm_addr  = 32'h200;
        dm_mode  = 3'b010;
        dm_we    = 1'b0;
        dm_req   = 1'b1;
        acks = 0;
        got  = 1'b0;
        for (int i = 0; i < 60; i++) begin
            step();
            if (if_ack) begin
                got = 1'b1;
                break;
            end
            if (dm_ack) begin
                acks++;
                if (acks == 5)
                    dm_req = 1'b0;
            end
        end
        if_req = 1'b0;
        dm_req = 1'b0;
        chk("starve dm acks", 32'(acks), 32'(EXP_DM));
        chk("starve if ack", 32'(got), 32'd1);
        step();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
